// File: rtl/mem_arbiter_if.sv
// Memory bus bundle: request strobes and fields from the initiator, wait/return from the target.
interface mem_arbiter_if;
  logic        read;
  logic        write;
  logic [1:0]  id;
  logic [29:0] address;
  logic [31:0] writedata;
  logic [3:0]  writedatamask;
  logic        waitrequest;
  logic [31:0] readdata;
  logic [1:0]  readdataid;

  modport master (
    output read, write, id, address, writedata, writedatamask,
    input  waitrequest, readdata, readdataid
  );

  modport slave (
    input  read, write, id, address, writedata, writedatamask,
    output waitrequest, readdata, readdataid
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-master arbiter onto one SRAM controller port, with an owner FIFO that routes
// read returns back to the master that issued them.
module mem_arbiter #(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic         clock,
  input  logic         rst_n,
  mem_arbiter_if.slave  m0_bus,
  mem_arbiter_if.slave  m1_bus,
  mem_arbiter_if.master s_bus,
  output logic         rsp_error
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [1:0] {StIdle, StGnt0, StGnt1} state_e;

  state_e                state_q, state_d;
  logic                  last_q, last_d;
  logic [FIFO_DEPTH-1:0] owner_q, owner_d;
  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]       count_q, count_d;
  logic                  rsp_error_q, rsp_error_d;

  logic req0, req1, gnt0, gnt1, gnt_sel;
  logic g_read, g_write, rsp_valid, full, blocked, accept, push, pop, head_owner;

  always_comb begin
    req0       = m0_bus.read | m0_bus.write;
    req1       = m1_bus.read | m1_bus.write;
    gnt0       = rst_n && (state_q == StGnt0);
    gnt1       = rst_n && (state_q == StGnt1);
    gnt_sel    = (state_q == StGnt1);
    g_read     = gnt_sel ? m1_bus.read  : m0_bus.read;
    g_write    = gnt_sel ? m1_bus.write : m0_bus.write;
    rsp_valid  = rst_n && (s_bus.readdataid != 2'd0);
    full       = (count_q == CntW'(FIFO_DEPTH));
    // A full FIFO still accepts a read when a response frees a slot this same cycle.
    blocked    = g_read && full && !rsp_valid;
    accept     = (gnt0 || gnt1) && (g_read || g_write) && !s_bus.waitrequest && !blocked;
    push       = accept && g_read;
    pop        = rsp_valid && (count_q != '0);
    head_owner = owner_q[rd_ptr_q];
  end

  always_comb begin
    s_bus.read          = (gnt0 || gnt1) && g_read && !blocked;
    s_bus.write         = (gnt0 || gnt1) && g_write && !blocked;
    s_bus.id            = gnt_sel ? m1_bus.id            : m0_bus.id;
    s_bus.address       = gnt_sel ? m1_bus.address       : m0_bus.address;
    s_bus.writedata     = gnt_sel ? m1_bus.writedata     : m0_bus.writedata;
    s_bus.writedatamask = gnt_sel ? m1_bus.writedatamask : m0_bus.writedatamask;

    m0_bus.waitrequest  = gnt0 ? (s_bus.waitrequest || blocked) : 1'b1;
    m1_bus.waitrequest  = gnt1 ? (s_bus.waitrequest || blocked) : 1'b1;
    m0_bus.readdata     = s_bus.readdata;
    m1_bus.readdata     = s_bus.readdata;
    m0_bus.readdataid   = (pop && !head_owner) ? s_bus.readdataid : 2'd0;
    m1_bus.readdataid   = (pop &&  head_owner) ? s_bus.readdataid : 2'd0;
    rsp_error           = rsp_error_q;
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    unique case (state_q)
      StIdle: begin
        if (req0 && req1) state_d = last_q ? StGnt0 : StGnt1;
        else if (req0)    state_d = StGnt0;
        else if (req1)    state_d = StGnt1;
      end
      // The accepted master is still requesting in its accept cycle, so it keeps the
      // grant unless the other master waits; a later drop is handled as a plain drop.
      StGnt0: begin
        if (accept) begin
          last_d  = 1'b0;
          state_d = req1 ? StGnt1 : StGnt0;
        end else if (!req0) begin
          state_d = StIdle;
        end
      end
      StGnt1: begin
        if (accept) begin
          last_d  = 1'b1;
          state_d = req0 ? StGnt0 : StGnt1;
        end else if (!req1) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    owner_d     = owner_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    if (push) begin
      owner_d[wr_ptr_q] = gnt_sel;
      wr_ptr_d          = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    count_d     = count_q + CntW'(push) - CntW'(pop);
    rsp_error_d = rsp_error_q || (rsp_valid && (count_q == '0));
  end

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      last_q      <= 1'b1;
      owner_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rsp_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      owner_q     <= owner_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      rsp_error_q <= rsp_error_d;
    end
  end

endmodule
